wb_regfile: RTL and testbench

Clocked writeback stage and architectural register file for the pipelined Y86-64 core. It commits the W pipeline register's `valE` and `valM` results into fifteen 64-bit registers and serves the decode stage's two combinational read ports. It tracks processor status through a RUN/HALTED state machine and counts retired instructions. It sits between the W pipeline register and decode, and is the writer side of the register-file interface that decode reads.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/y86_rf_core.sv | 56 +++++
 rtl/wb_regfile.sv | 106 ++++++++++
 tb/tb_wb_regfile.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 status, icode and register-id constants
package y86_pkg;

    // Processor status codes carried down the pipeline
    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register identifiers; 4'hF is the "no register" encoding
    localparam logic [3:0] R_RAX = 4'h0;
    localparam logic [3:0] R_RCX = 4'h1;
    localparam logic [3:0] R_RDX = 4'h2;
    localparam logic [3:0] R_RBX = 4'h3;
    localparam logic [3:0] R_RSP = 4'h4;
    localparam logic [3:0] R_RBP = 4'h5;
    localparam logic [3:0] R_RSI = 4'h6;
    localparam logic [3:0] R_RDI = 4'h7;
    localparam logic [3:0] R_R8  = 4'h8;
    localparam logic [3:0] R_R9  = 4'h9;
    localparam logic [3:0] R_R10 = 4'hA;
    localparam logic [3:0] R_R11 = 4'hB;
    localparam logic [3:0] R_R12 = 4'hC;
    localparam logic [3:0] R_R13 = 4'hD;
    localparam logic [3:0] R_R14 = 4'hE;
    localparam logic [3:0] RRSP  = R_RSP;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NREGS = 15;

    // Writeback status machine states
    typedef enum logic {
        S_RUN,
        S_HALTED
    } wb_state_e;

endpackage

// File: rtl/y86_rf_core.sv
// rtl/y86_rf_core.sv - 15x64 register storage, two write ports, three read ports
module y86_rf_core
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    input  logic [3:0]  src_dbg,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b,
    output logic [63:0] rval_dbg
);

    logic [63:0] regs_q [NREGS];
    logic [63:0] regs_d [NREGS];

    // Next register values; the M port is applied last so it wins a shared destination
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_e && (dst_e == 4'(i))) regs_d[i] = val_e;
            if (we_m && (dst_m == 4'(i))) regs_d[i] = val_m;
        end
    end

    // Storage update; %rsp comes out of reset at the configured stack top
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (4'(i) == RRSP) ? STACK_INIT : 64'h0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // Read ports see stored state only; decode forwards in-flight W values itself
    always_comb begin
        rval_a   = 64'h0;
        rval_b   = 64'h0;
        rval_dbg = 64'h0;
        if (src_a   != RNONE) rval_a   = regs_q[src_a];
        if (src_b   != RNONE) rval_b   = regs_q[src_b];
        if (src_dbg != RNONE) rval_dbg = regs_q[src_dbg];
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - Y86-64 writeback stage: commit, status machine, retire counter
module wb_regfile
    import y86_pkg::*;
#(
    parameter logic [63:0] STACK_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [63:0] retired
);

    wb_state_e   state_q, state_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] retired_q, retired_d;
    logic        we_e, we_m;

    // State, status and retire count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            stat_q    <= STAT_AOK;
            retired_q <= 64'h0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    // Next state: any halting status freezes the machine; unknown codes 5-7 report INS
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        if (state_q == S_RUN) begin
            case (W_stat)
                STAT_BUB, STAT_AOK: ;
                STAT_HLT: begin
                    state_d = S_HALTED;
                    stat_d  = STAT_HLT;
                end
                STAT_ADR: begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end
                default: begin
                    state_d = S_HALTED;
                    stat_d  = STAT_INS;
                end
            endcase
        end
    end

    // Commit controls: only AOK writes; AOK non-NOP and HLT retire
    always_comb begin
        we_e      = 1'b0;
        we_m      = 1'b0;
        retired_d = retired_q;
        if (state_q == S_RUN) begin
            if (W_stat == STAT_AOK) begin
                we_e = (W_dstE != RNONE);
                we_m = (W_dstM != RNONE);
                if (W_icode != I_NOP) retired_d = retired_q + 64'd1;
            end else if (W_stat == STAT_HLT) begin
                retired_d = retired_q + 64'd1;
            end
        end
    end

    y86_rf_core #(
        .STACK_INIT(STACK_INIT)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_e     (we_e),
        .dst_e    (W_dstE),
        .val_e    (W_valE),
        .we_m     (we_m),
        .dst_m    (W_dstM),
        .val_m    (W_valM),
        .src_a    (d_srcA),
        .src_b    (d_srcB),
        .src_dbg  (dbg_sel),
        .rval_a   (d_rvalA),
        .rval_b   (d_rvalB),
        .rval_dbg (dbg_val)
    );

    assign cpu_stat = stat_q;
    assign halted   = (state_q == S_HALTED);
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed scoreboard bench for wb_regfile
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [63:0] W_valE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [3:0]  dbg_sel;
    logic [63:0] dbg_val;
    logic [2:0]  cpu_stat;
    logic        halted;
    logic [63:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q [$];

    wb_regfile #(
        .STACK_INIT(64'h200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .W_stat   (W_stat),
        .W_icode  (W_icode),
        .W_dstE   (W_dstE),
        .W_valE   (W_valE),
        .W_dstM   (W_dstM),
        .W_valM   (W_valM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_rvalA  (d_rvalA),
        .d_rvalB  (d_rvalB),
        .dbg_sel  (dbg_sel),
        .dbg_val  (dbg_val),
        .cpu_stat (cpu_stat),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic bubble();
        W_stat  = 3'd0;
        W_icode = 4'h1;
        W_dstE  = 4'hF;
        W_valE  = 64'h0;
        W_dstM  = 4'hF;
        W_valM  = 64'h0;
    endtask

    // Present one W instruction half a cycle ahead of the committing edge
    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        @(negedge clk);
        W_stat  = st;
        W_icode = ic;
        W_dstE  = de;
        W_valE  = ve;
        W_dstM  = dm;
        W_valM  = vm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] r, input logic [63:0] v);
        dbg_sel = r;
        #1;
        push(v);
        check(tag, dbg_val);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bubble();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic [2:0] st,
                                input logic h, input logic [63:0] ret);
        push({61'h0, st});
        check({tag, "_stat"}, {61'h0, cpu_stat});
        push({63'h0, h});
        check({tag, "_halted"}, {63'h0, halted});
        push(ret);
        check({tag, "_retired"}, retired);
    endtask

    initial begin
        rst_n   = 1'b0;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        dbg_sel = 4'hF;
        bubble();
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset state
        check_status("rst", 3'd1, 1'b0, 64'h0);
        for (int r = 0; r < 15; r++)
            check_reg($sformatf("rst_reg%0d", r), 4'(r), (r == 4) ? 64'h200 : 64'h0);
        check_reg("rst_dbgF", 4'hF, 64'h0);
        push(64'h0);
        check("rst_rvalA_F", d_rvalA);

        // OPq to %rdx: old value this cycle, new value next cycle
        d_srcA = 4'h2;
        drive(3'd1, 4'h6, 4'h2, 64'h1234, 4'hF, 64'h0);
        push(64'h0);
        check("opq_same_cycle", d_rvalA);
        tick();
        bubble();
        push(64'h1234);
        check("opq_next_cycle", d_rvalA);
        push(64'h1);
        check("opq_retired", retired);

        // popq %rsp: M result wins over E
        d_srcB = 4'h4;
        drive(3'd1, 4'hB, 4'h4, 64'h208, 4'h4, 64'hABCD);
        push(64'h200);
        check("popq_old", d_rvalB);
        tick();
        bubble();
        push(64'hABCD);
        check("popq_rsp", d_rvalB);
        push(64'h2);
        check("popq_retired", retired);

        // AOK with no destinations counts; AOK NOP does not
        drive(3'd1, 4'h6, 4'hF, 64'hDEAD, 4'hF, 64'hBEEF);
        tick();
        drive(3'd1, 4'h1, 4'hF, 64'h1111, 4'hF, 64'h2222);
        tick();
        bubble();
        push(64'h3);
        check("nodst_nop_retired", retired);
        check_reg("nodst_reg2", 4'h2, 64'h1234);
        check_reg("nodst_reg4", 4'h4, 64'hABCD);
        check_reg("nodst_reg0", 4'h0, 64'h0);

        // ADR faults: no write, halt, later AOK ignored
        drive(3'd3, 4'h5, 4'h3, 64'h55, 4'hF, 64'h0);
        push(64'h0);
        check("adr_halted_before", {63'h0, halted});
        tick();
        W_stat = 3'd1; W_icode = 4'h3; W_dstE = 4'h3; W_valE = 64'h99;
        check_status("adr", 3'd3, 1'b1, 64'h3);
        check_reg("adr_reg3", 4'h3, 64'h0);
        tick();
        bubble();
        check_reg("adr_after_aok_reg3", 4'h3, 64'h0);
        check_status("adr_after", 3'd3, 1'b1, 64'h3);

        // Unknown status code halts as INS
        do_reset();
        drive(3'd6, 4'h6, 4'h1, 64'h77, 4'hF, 64'h0);
        tick();
        bubble();
        check_status("ins6", 3'd4, 1'b1, 64'h0);
        check_reg("ins6_reg1", 4'h1, 64'h0);

        // HLT retires and halts; reset from HALTED restores everything
        do_reset();
        drive(3'd1, 4'h2, 4'h2, 64'h42, 4'hF, 64'h0);
        tick();
        drive(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
        tick();
        bubble();
        check_status("hlt", 3'd2, 1'b1, 64'h2);
        drive(3'd1, 4'h6, 4'h5, 64'h5555, 4'hF, 64'h0);
        tick();
        bubble();
        check_reg("hlt_ignored_reg5", 4'h5, 64'h0);
        check_status("hlt_frozen", 3'd2, 1'b1, 64'h2);
        do_reset();
        check_status("rst2", 3'd1, 1'b0, 64'h0);
        check_reg("rst2_reg2", 4'h2, 64'h0);
        check_reg("rst2_reg4", 4'h4, 64'h200);
        drive(3'd1, 4'h3, 4'h1, 64'h7, 4'hF, 64'h0);
        tick();
        bubble();
        check_reg("rst2_reg1", 4'h1, 64'h7);
        push(64'h1);
        check("rst2_retired", retired);

        // Distinct E and M destinations in one commit
        drive(3'd1, 4'h5, 4'hE, 64'hE0, 4'h0, 64'hA0);
        tick();
        bubble();
        check_reg("dual_regE", 4'hE, 64'hE0);
        check_reg("dual_reg0", 4'h0, 64'hA0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
